// File: rtl/window_gen_3x3_pkg.sv
// Shared constants for the 3x3 window generator: pixel width, window slot
// indices (downstream 9-entry pixel array order) and default frame geometry.
package window_gen_3x3_pkg;

    localparam int unsigned PIX_W          = 8;

    localparam int unsigned IDX_A          = 0;
    localparam int unsigned IDX_B          = 1;
    localparam int unsigned IDX_C          = 2;
    localparam int unsigned IDX_D          = 3;
    localparam int unsigned IDX_FIJ        = 4;
    localparam int unsigned IDX_E          = 5;
    localparam int unsigned IDX_F          = 6;
    localparam int unsigned IDX_G          = 7;
    localparam int unsigned IDX_H          = 8;
    localparam int unsigned WIN_SIZE       = 9;

    localparam int unsigned DEF_IMG_WIDTH  = 64;
    localparam int unsigned DEF_IMG_HEIGHT = 64;

endpackage

// File: rtl/window_gen_3x3_line_buffer.sv
// One image line of pixel storage: asynchronous read, synchronous write,
// single shared address, so a same-cycle read returns the pre-write data.
module window_gen_3x3_line_buffer
    import window_gen_3x3_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             iClk,
    input  logic             iWe,
    input  logic [AW-1:0]    ivAddr,
    input  logic [PIX_W-1:0] ivWrData,
    output logic [PIX_W-1:0] ovRdData
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge iClk) begin
        if (iWe) begin
            mem[ivAddr] <= ivWrData;
        end
    end

    assign ovRdData = mem[ivAddr];

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed a 3x3 shift
// window; only interior centres are flagged valid, one cycle after acceptance.
module window_gen_3x3
    import window_gen_3x3_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int CNT_W      = $clog2((IMG_WIDTH > IMG_HEIGHT) ? IMG_WIDTH : IMG_HEIGHT)
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iSof,
    input  logic             iPixelValid,
    input  logic [PIX_W-1:0] iv8Pixel,
    output logic [PIX_W-1:0] ov8Pixel_a,
    output logic [PIX_W-1:0] ov8Pixel_b,
    output logic [PIX_W-1:0] ov8Pixel_c,
    output logic [PIX_W-1:0] ov8Pixel_d,
    output logic [PIX_W-1:0] ov8Pixel_fij,
    output logic [PIX_W-1:0] ov8Pixel_e,
    output logic [PIX_W-1:0] ov8Pixel_f,
    output logic [PIX_W-1:0] ov8Pixel_g,
    output logic [PIX_W-1:0] ov8Pixel_h,
    output logic             oWindowValid,
    output logic [CNT_W-1:0] ovCentreRow,
    output logic [CNT_W-1:0] ovCentreCol,
    output logic             oFrameDone,
    output logic             oFrameAbort
);

    localparam int LB_AW = $clog2(IMG_WIDTH);
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_WIDTH - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_HEIGHT - 1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] crow_q, crow_d;
    logic [CNT_W-1:0] ccol_q, ccol_d;
    logic [WIN_SIZE-1:0][PIX_W-1:0] win_q, win_d;
    logic valid_q, valid_d;
    logic done_q, done_d;
    logic abort_q, abort_d;

    logic             accept;
    logic [CNT_W-1:0] col_eff;
    logic [CNT_W-1:0] row_eff;
    logic [PIX_W-1:0] rd1;
    logic [PIX_W-1:0] rd2;

    assign accept  = iPixelValid;
    // iSof relocates the accepted pixel to (0,0) before any addressing
    assign col_eff = iSof ? '0 : col_q;
    assign row_eff = iSof ? '0 : row_q;

    window_gen_3x3_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .AW    (LB_AW)
    ) u_lb1 (
        .iClk     (iClk),
        .iWe      (accept),
        .ivAddr   (col_eff[LB_AW-1:0]),
        .ivWrData (iv8Pixel),
        .ovRdData (rd1)
    );

    window_gen_3x3_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .AW    (LB_AW)
    ) u_lb2 (
        .iClk     (iClk),
        .iWe      (accept),
        .ivAddr   (col_eff[LB_AW-1:0]),
        .ivWrData (rd1),
        .ovRdData (rd2)
    );

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        crow_d  = crow_q;
        ccol_d  = ccol_q;
        win_d   = win_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        abort_d = 1'b0;
        if (accept) begin
            abort_d = iSof && ((col_q != '0) || (row_q != '0));
            if (col_eff == COL_LAST) begin
                col_d = '0;
                row_d = (row_eff == ROW_LAST) ? '0 : row_eff + ONE;
            end else begin
                col_d = col_eff + ONE;
                row_d = row_eff;
            end

            win_d[IDX_A]   = win_q[IDX_B];
            win_d[IDX_B]   = win_q[IDX_C];
            win_d[IDX_C]   = rd2;
            win_d[IDX_D]   = win_q[IDX_FIJ];
            win_d[IDX_FIJ] = win_q[IDX_E];
            win_d[IDX_E]   = rd1;
            win_d[IDX_F]   = win_q[IDX_G];
            win_d[IDX_G]   = win_q[IDX_H];
            win_d[IDX_H]   = iv8Pixel;

            // Stale wrap-around columns at col 0/1 are masked here
            if ((row_eff >= TWO) && (col_eff >= TWO)) begin
                valid_d = 1'b1;
                crow_d  = row_eff - ONE;
                ccol_d  = col_eff - ONE;
            end
            done_d = (row_eff == ROW_LAST) && (col_eff == COL_LAST);
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            col_q   <= '0;
            row_q   <= '0;
            crow_q  <= '0;
            ccol_q  <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            crow_q  <= crow_d;
            ccol_q  <= ccol_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign ov8Pixel_a   = win_q[IDX_A];
    assign ov8Pixel_b   = win_q[IDX_B];
    assign ov8Pixel_c   = win_q[IDX_C];
    assign ov8Pixel_d   = win_q[IDX_D];
    assign ov8Pixel_fij = win_q[IDX_FIJ];
    assign ov8Pixel_e   = win_q[IDX_E];
    assign ov8Pixel_f   = win_q[IDX_F];
    assign ov8Pixel_g   = win_q[IDX_G];
    assign ov8Pixel_h   = win_q[IDX_H];
    assign oWindowValid = valid_q;
    assign ovCentreRow  = crow_q;
    assign ovCentreCol  = ccol_q;
    assign oFrameDone   = done_q;
    assign oFrameAbort  = abort_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3 on a 5x4 frame: an image-array reference model
// predicts every window, pulse and held output cycle by cycle.
module tb_window_gen_3x3;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int CW = 3;
    localparam int WH = W * H;

    logic          iClk = 1'b0;
    logic          iRst = 1'b0;
    logic          iSof = 1'b0;
    logic          iPixelValid = 1'b0;
    logic [7:0]    iv8Pixel = '0;
    logic [7:0]    pa, pb, pc, pd, pfij, pe, pf, pg, ph;
    logic          oWindowValid, oFrameDone, oFrameAbort;
    logic [CW-1:0] ovCentreRow, ovCentreCol;

    window_gen_3x3 #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .CNT_W      (CW)
    ) dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .iSof         (iSof),
        .iPixelValid  (iPixelValid),
        .iv8Pixel     (iv8Pixel),
        .ov8Pixel_a   (pa),
        .ov8Pixel_b   (pb),
        .ov8Pixel_c   (pc),
        .ov8Pixel_d   (pd),
        .ov8Pixel_fij (pfij),
        .ov8Pixel_e   (pe),
        .ov8Pixel_f   (pf),
        .ov8Pixel_g   (pg),
        .ov8Pixel_h   (ph),
        .oWindowValid (oWindowValid),
        .ovCentreRow  (ovCentreRow),
        .ovCentreCol  (ovCentreCol),
        .oFrameDone   (oFrameDone),
        .oFrameAbort  (oFrameAbort)
    );

    always #5 iClk = ~iClk;

    int total = 0;
    int bad   = 0;

    // Reference model state: pixel index within frame and the frame image
    int          n = 0;
    logic [7:0]  img [H][W];
    logic [71:0] exp_win = '0;
    int          exp_row = 0;
    int          exp_col = 0;
    bit          win_known = 1'b1;
    int          win_cnt = 0;
    int          done_cnt = 0;
    int          abort_cnt = 0;
    bit          grab_first = 1'b0;
    logic [71:0] first_win = '0;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] outs_win();
        return {pa, pb, pc, pd, pfij, pe, pf, pg, ph};
    endfunction

    task automatic step(input logic v, input logic s, input logic [7:0] p);
        int pos, r, c;
        bit e_valid, e_done, e_abort;
        e_valid = 0; e_done = 0; e_abort = 0;
        iPixelValid = v; iSof = s; iv8Pixel = p;
        if (v) begin
            if (s) begin
                e_abort = (n != 0);
                n = 0;
            end
            pos = n;
            r = pos / W;
            c = pos % W;
            img[r][c] = p;
            e_valid = (r >= 2) && (c >= 2);
            e_done  = (pos == WH - 1);
            if (e_valid) begin
                exp_win = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                           img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                           img[r][c-2],   img[r][c-1],   img[r][c]};
                exp_row = r - 1;
                exp_col = c - 1;
                win_known = 1'b1;
            end else begin
                win_known = 1'b0;
            end
            n = (n + 1) % WH;
        end
        @(posedge iClk);
        #1;
        iPixelValid = 1'b0; iSof = 1'b0;
        chk("valid", 72'(oWindowValid), 72'(e_valid));
        chk("done",  72'(oFrameDone),   72'(e_done));
        chk("abort", 72'(oFrameAbort),  72'(e_abort));
        chk("crow",  72'(ovCentreRow),  72'(exp_row));
        chk("ccol",  72'(ovCentreCol),  72'(exp_col));
        if (win_known) chk("window", outs_win(), exp_win);
        if (oWindowValid) begin
            win_cnt++;
            if (grab_first) begin
                first_win = outs_win();
                grab_first = 1'b0;
            end
        end
        if (oFrameDone)  done_cnt++;
        if (oFrameAbort) abort_cnt++;
    endtask

    task automatic stall(input int pct);
        while ($urandom_range(99) < pct) step(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic send_frame(input int base, input int pct, input bit rnd);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                stall(pct);
                step(1'b1, (r == 0) && (c == 0), rnd ? 8'($urandom) : 8'(base + r * 16 + c));
            end
        end
    endtask

    task automatic clear_counts();
        win_cnt = 0; done_cnt = 0; abort_cnt = 0;
    endtask

    initial begin
        // Reset state
        #1;
        chk("reset_outs", {outs_win(), 72'(0)} >> 72, '0);
        chk("reset_flags", 72'({oWindowValid, oFrameDone, oFrameAbort, ovCentreRow, ovCentreCol}), '0);
        @(posedge iClk); #1;
        iRst = 1'b1;
        @(posedge iClk); #1;

        // Basic frame, continuous
        clear_counts();
        grab_first = 1'b1;
        send_frame(0, 0, 1'b0);
        chk("basic_windows", 72'(win_cnt), 72'd6);
        chk("basic_done", 72'(done_cnt), 72'd1);
        chk("first_window", first_win, 72'h00_01_02_10_11_12_20_21_22);
        chk("last_fij", 72'(pfij), 72'h23);
        chk("last_h", 72'(ph), 72'h34);
        chk("last_centre", 72'({ovCentreRow, ovCentreCol}), 72'({3'd2, 3'd3}));

        // Same frame with ~50% stalls
        clear_counts();
        send_frame(0, 50, 1'b0);
        chk("stall_windows", 72'(win_cnt), 72'd6);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'($urandom));

        // Back-to-back frames, no idle gap
        clear_counts();
        send_frame(0, 0, 1'b0);
        grab_first = 1'b1;
        send_frame(8'h80, 0, 1'b0);
        chk("b2b_windows", 72'(win_cnt), 72'd12);
        chk("b2b_first", first_win, 72'h80_81_82_90_91_92_a0_a1_a2);

        // Early iSof after 7 pixels
        clear_counts();
        for (int i = 0; i < 7; i++) step(1'b1, i == 0, 8'((i / W) * 16 + (i % W)));
        send_frame(0, 0, 1'b0);
        chk("early_abort", 72'(abort_cnt), 72'd1);
        chk("early_windows", 72'(win_cnt), 72'd6);

        // Mid-frame reset after pixel (2,3)
        for (int i = 0; i < 2 * W + 4; i++) step(1'b1, i == 0, 8'((i / W) * 16 + (i % W)));
        iRst = 1'b0;
        #1;
        chk("mreset_outs", outs_win(), '0);
        chk("mreset_flags", 72'({oWindowValid, oFrameDone, oFrameAbort, ovCentreRow, ovCentreCol}), '0);
        n = 0; exp_win = '0; exp_row = 0; exp_col = 0; win_known = 1'b1;
        @(posedge iClk); @(posedge iClk); #1;
        iRst = 1'b1;
        clear_counts();
        send_frame(0, 0, 1'b0);
        chk("mreset_windows", 72'(win_cnt), 72'd6);

        // Random pixel values with stalls
        clear_counts();
        send_frame(0, 40, 1'b1);
        send_frame(0, 40, 1'b1);
        chk("rand_windows", 72'(win_cnt), 72'd12);
        chk("rand_done", 72'(done_cnt), 72'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
